// File: rtl/la_counter_pkg.sv
// Shared constants and types for the LA-controlled counter bank.
// Latency: n/a. Backpressure: n/a.
package la_counter_pkg;

    localparam int unsigned MAX_CHANNELS = 16;
    localparam int unsigned STAGES       = 2;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

endpackage

// File: rtl/la_sync_edge.sv
// Multi-flop synchroniser for an asynchronous LA probe plus a registered rising-edge pulse.
// Latency: level after DEPTH cycles, edge pulse one cycle later. Backpressure: none.
module la_sync_edge
    import la_counter_pkg::*;
#(
    parameter int unsigned DEPTH = STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic edge_o
);

    logic [DEPTH-1:0] sync_q, sync_d;
    logic             prev_q, prev_d;
    logic             edge_q, edge_d;

    always_comb begin
        sync_d = (sync_q << 1) | DEPTH'(async_i);
        prev_d = sync_q[DEPTH-1];
        edge_d = sync_q[DEPTH-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign level_o = sync_q[DEPTH-1];
    assign edge_o  = edge_q;

endmodule

// File: rtl/la_counter_bank.sv
// Bank of settable up/down counters with wrap/saturate, sticky overflow and LA single-step.
// Latency: loads/updates visible 1 cycle after the edge; step tick 3 cycles after testStep rises. Backpressure: none.
module la_counter_bank
    import la_counter_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned INCREMENT = 1,
    parameter int unsigned SATURATE  = 0,
    localparam int unsigned CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      externalClock,
    input  logic                      externalReset_n,
    input  logic                      stepMode,
    input  logic                      testStep,
    input  logic                      testReset,
    input  logic [CHANNELS-1:0]       chanEnable,
    input  logic [CHANNELS-1:0]       downMode,
    input  logic                      setValid,
    input  logic [CW-1:0]             setChan,
    input  logic [WIDTH-1:0]          setValue,
    input  logic                      overflowClear,
    output logic [CHANNELS*WIDTH-1:0] count_o,
    output logic [CHANNELS-1:0]       overflow_o,
    output logic                      tick_o
);

    localparam logic [WIDTH:0] INC_EXT = (WIDTH+1)'(INCREMENT);

    if (CHANNELS < 1 || CHANNELS > MAX_CHANNELS) begin : g_bad_cfg
        $error("la_counter_bank: CHANNELS out of range");
    end

    logic step_edge, step_level;
    logic clr_level, clr_edge;
    logic tick;
    logic tick_q, tick_d;
    logic unused_sync;

    la_sync_edge #(.DEPTH(STAGES)) u_step_sync (
        .clk     (externalClock),
        .rst_n   (externalReset_n),
        .async_i (testStep),
        .level_o (step_level),
        .edge_o  (step_edge)
    );

    la_sync_edge #(.DEPTH(STAGES)) u_clr_sync (
        .clk     (externalClock),
        .rst_n   (externalReset_n),
        .async_i (testReset),
        .level_o (clr_level),
        .edge_o  (clr_edge)
    );

    assign unused_sync = step_level ^ clr_edge;

    // The edge detector always runs, so flipping stepMode cannot fabricate a tick.
    always_comb begin
        tick   = stepMode ? step_edge : 1'b1;
        tick_d = tick;
    end

    always_ff @(posedge externalClock or negedge externalReset_n) begin
        if (!externalReset_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             ovf_q, ovf_d;
        logic [WIDTH:0]   sum;
        dir_e             dir;

        // Top bit of the widened sum is the carry (up) or borrow (down).
        always_comb begin
            dir   = downMode[i] ? DIR_DOWN : DIR_UP;
            sum   = (dir == DIR_DOWN) ? ({1'b0, cnt_q} - INC_EXT) : ({1'b0, cnt_q} + INC_EXT);
            cnt_d = cnt_q;
            ovf_d = ovf_q & ~overflowClear;
            if (clr_level) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (setValid && setChan == CW'(i)) begin
                cnt_d = setValue;
            end else if (tick && chanEnable[i]) begin
                cnt_d = sum[WIDTH-1:0];
                if (sum[WIDTH]) begin
                    ovf_d = 1'b1;
                    if (SATURATE != 0) begin
                        cnt_d = (dir == DIR_DOWN) ? '0 : '1;
                    end
                end
            end
        end

        always_ff @(posedge externalClock or negedge externalReset_n) begin
            if (!externalReset_n) begin
                cnt_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ovf_q <= ovf_d;
            end
        end

        assign count_o[i*WIDTH +: WIDTH] = cnt_q;
        assign overflow_o[i]             = ovf_q;
    end

endmodule

// File: tb/tb_la_counter_bank.sv
// Bench for la_counter_bank: wrap and saturate instances driven in lockstep against a
// sample-history reference model, plus a 3-channel instance for out-of-range loads.
`timescale 1ns/1ps
module tb_la_counter_bank;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int INC = 1;
    localparam int MAXV = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          stepMode, testStep, testReset, setValid, overflowClear;
    logic [CH-1:0] chanEnable, downMode;
    logic [1:0]    setChan;
    logic [W-1:0]  setValue;

    logic [CH*W-1:0] count_w, count_s;
    logic [CH-1:0]   ovf_w, ovf_s;
    logic            tick_w, tick_s;

    logic        s_setValid;
    logic [1:0]  s_setChan;
    logic [7:0]  s_setValue;
    logic [23:0] s_count;
    logic [2:0]  s_ovf;
    logic        s_tick;

    la_counter_bank #(.CHANNELS(CH), .WIDTH(W), .INCREMENT(INC), .SATURATE(0)) u_wrap (
        .externalClock(clk), .externalReset_n(rst_n), .stepMode(stepMode), .testStep(testStep),
        .testReset(testReset), .chanEnable(chanEnable), .downMode(downMode), .setValid(setValid),
        .setChan(setChan), .setValue(setValue), .overflowClear(overflowClear),
        .count_o(count_w), .overflow_o(ovf_w), .tick_o(tick_w)
    );

    la_counter_bank #(.CHANNELS(CH), .WIDTH(W), .INCREMENT(INC), .SATURATE(1)) u_sat (
        .externalClock(clk), .externalReset_n(rst_n), .stepMode(stepMode), .testStep(testStep),
        .testReset(testReset), .chanEnable(chanEnable), .downMode(downMode), .setValid(setValid),
        .setChan(setChan), .setValue(setValue), .overflowClear(overflowClear),
        .count_o(count_s), .overflow_o(ovf_s), .tick_o(tick_s)
    );

    la_counter_bank #(.CHANNELS(3), .WIDTH(8), .INCREMENT(1), .SATURATE(0)) u_small (
        .externalClock(clk), .externalReset_n(rst_n), .stepMode(1'b1), .testStep(1'b0),
        .testReset(1'b0), .chanEnable(3'b000), .downMode(3'b000), .setValid(s_setValid),
        .setChan(s_setChan), .setValue(s_setValue), .overflowClear(1'b0),
        .count_o(s_count), .overflow_o(s_ovf), .tick_o(s_tick)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference state: counts as plain integers, input sample histories per edge.
    int m_cnt[2][CH];
    bit m_ovf[2][CH];
    bit m_tick_o;
    bit h_step[5];
    bit h_rst[3];

    function automatic void model_reset();
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < CH; i++) begin
                m_cnt[m][i] = 0;
                m_ovf[m][i] = 1'b0;
            end
        for (int k = 0; k < 5; k++) h_step[k] = 1'b0;
        for (int k = 0; k < 3; k++) h_rst[k] = 1'b0;
        m_tick_o = 1'b0;
    endfunction

    // One clock edge: step tick fires 3 edges after the first high sample; clear acts 2 edges after sampling.
    function automatic void model_edge();
        bit tk, clr, ev;
        for (int k = 4; k > 0; k--) h_step[k] = h_step[k-1];
        h_step[0] = testStep;
        for (int k = 2; k > 0; k--) h_rst[k] = h_rst[k-1];
        h_rst[0] = testReset;
        tk  = stepMode ? (h_step[3] && !h_step[4]) : 1'b1;
        clr = h_rst[2];
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < CH; i++) begin
                if (clr) begin
                    m_cnt[m][i] = 0;
                    m_ovf[m][i] = 1'b0;
                end else begin
                    ev = 1'b0;
                    if (setValid && int'(setChan) == i) begin
                        m_cnt[m][i] = int'(setValue);
                    end else if (tk && chanEnable[i]) begin
                        if (downMode[i]) begin
                            if (m_cnt[m][i] < INC) begin
                                ev = 1'b1;
                                m_cnt[m][i] = (m == 1) ? 0 : m_cnt[m][i] - INC + MAXV + 1;
                            end else m_cnt[m][i] = m_cnt[m][i] - INC;
                        end else begin
                            if (m_cnt[m][i] + INC > MAXV) begin
                                ev = 1'b1;
                                m_cnt[m][i] = (m == 1) ? MAXV : m_cnt[m][i] + INC - MAXV - 1;
                            end else m_cnt[m][i] = m_cnt[m][i] + INC;
                        end
                    end
                    m_ovf[m][i] = (m_ovf[m][i] && !overflowClear) || ev;
                end
            end
        end
        m_tick_o = tk;
    endfunction

    task automatic cyc();
        logic [CH*W-1:0] ec [2];
        logic [CH-1:0]   eo [2];
        model_edge();
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < CH; i++) begin
                ec[m][i*W +: W] = m_cnt[m][i][W-1:0];
                eo[m][i]        = m_ovf[m][i];
            end
        chk("count_wrap", count_w, ec[0]);
        chk("count_sat",  count_s, ec[1]);
        chk("ovf_wrap", 32'(ovf_w), 32'(eo[0]));
        chk("ovf_sat",  32'(ovf_s), 32'(eo[1]));
        chk("tick_wrap", 32'(tick_w), 32'(m_tick_o));
        chk("tick_sat",  32'(tick_s), 32'(m_tick_o));
    endtask

    task automatic idle_inputs();
        testReset = 1'b0; setValid = 1'b0; setChan = 2'd0; setValue = '0;
        overflowClear = 1'b0; chanEnable = '0; downMode = '0;
    endtask

    initial begin
        int hi, at;
        logic [7:0] pick [5];
        stepMode = 1'b0; testStep = 1'b0;
        idle_inputs();
        s_setValid = 1'b0; s_setChan = 2'd0; s_setValue = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count_wrap", count_w, 32'h0);
        chk("rst_count_sat",  count_s, 32'h0);
        chk("rst_ovf", 32'({ovf_w, ovf_s}), 32'h0);
        chk("rst_tick", 32'({tick_w, tick_s, s_tick}), 32'h0);
        #3 rst_n = 1'b1;
        model_reset();

        // Free-run on channel 0 only.
        chanEnable = 4'b0001;
        repeat (10) cyc();
        chk("freerun_ch0", 32'(count_w[7:0]), 32'd10);
        chk("freerun_ch123", 32'(count_w[31:8]), 32'd0);
        chk("freerun_tick", 32'(tick_w), 32'd1);

        // Clear via the LA clear probe, then single-step three times.
        chanEnable = '0;
        testReset = 1'b1; repeat (3) cyc();
        testReset = 1'b0; repeat (3) cyc();
        stepMode = 1'b1; chanEnable = 4'hF;
        for (int p = 0; p < 3; p++) begin
            hi = 0; at = -1;
            for (int c = 0; c < 8; c++) begin
                testStep = (c < 2);
                cyc();
                if (tick_w) begin hi++; at = c; end
            end
            chk("step_pulse_width", 32'(hi), 32'd1);
            chk("step_pulse_lat", 32'(at), 32'd3);
        end
        chk("step_counts_wrap", count_w, 32'h03030303);
        chk("step_counts_sat",  count_s, 32'h03030303);

        // Up through the top: wrap vs clamp.
        stepMode = 1'b0; chanEnable = '0;
        setValid = 1'b1; setChan = 2'd1; setValue = 8'hFE; cyc();
        setValid = 1'b0; chanEnable = 4'b0010; repeat (3) cyc();
        chanEnable = '0;
        chk("wrap_up_cnt", 32'(count_w[15:8]), 32'h01);
        chk("sat_up_cnt",  32'(count_s[15:8]), 32'hFF);
        chk("wrap_up_ovf", 32'(ovf_w[1]), 32'd1);
        chk("sat_up_ovf",  32'(ovf_s[1]), 32'd1);

        // Down through zero, with the flag cleared first.
        overflowClear = 1'b1; setValid = 1'b1; setChan = 2'd1; setValue = 8'h00; downMode = 4'b0010; cyc();
        overflowClear = 1'b0; setValid = 1'b0; chanEnable = 4'b0010; cyc();
        chanEnable = '0; downMode = '0;
        chk("wrap_down_cnt", 32'(count_w[15:8]), 32'hFF);
        chk("sat_down_cnt",  32'(count_s[15:8]), 32'h00);
        chk("wrap_down_ovf", 32'(ovf_w[1]), 32'd1);
        chk("sat_down_ovf",  32'(ovf_s[1]), 32'd1);

        // Load beats tick.
        chanEnable = 4'b0100; setValid = 1'b1; setChan = 2'd2; setValue = 8'h55; cyc();
        setValid = 1'b0; chanEnable = '0;
        chk("prio_load", 32'(count_w[23:16]), 32'h55);

        // Clear beats load.
        testReset = 1'b1; setValid = 1'b1; setChan = 2'd3; setValue = 8'hAA; repeat (3) cyc();
        testReset = 1'b0; setValid = 1'b0; repeat (3) cyc();
        chk("clr_counts", count_w | count_s, 32'h0);
        chk("clr_ovf", 32'(ovf_w | ovf_s), 32'h0);

        // Set wins over a simultaneous clear; a later lone clear drops the flag.
        setValid = 1'b1; setChan = 2'd1; setValue = 8'hFF; cyc();
        setValid = 1'b0; chanEnable = 4'b0010; overflowClear = 1'b1; cyc();
        chanEnable = '0; overflowClear = 1'b0;
        chk("sticky_set_wins_wrap", 32'(ovf_w[1]), 32'd1);
        chk("sticky_set_wins_sat",  32'(ovf_s[1]), 32'd1);
        overflowClear = 1'b1; cyc();
        overflowClear = 1'b0;
        chk("sticky_cleared", 32'(ovf_w[1] | ovf_s[1]), 32'd0);

        // Out-of-range channel index on a 3-channel bank.
        for (int c = 0; c < 4; c++) begin
            s_setValid = 1'b1; s_setChan = 2'(c); s_setValue = 8'(8'h11 * (c + 1) + ((c == 3) ? 8'h55 : 8'h00));
            cyc();
        end
        s_setValid = 1'b0; cyc();
        chk("oor_load_ignored", 32'(s_count), 32'h332211);
        chk("oor_ovf", 32'(s_ovf), 32'd0);

        // Async reset half a cycle long while a step is in flight.
        stepMode = 1'b0; chanEnable = 4'hF; repeat (3) cyc();
        stepMode = 1'b1;
        testStep = 1'b1; cyc();
        testStep = 1'b0; cyc();
        #3 rst_n = 1'b0;
        #1;
        chk("arst_count", count_w | count_s, 32'h0);
        chk("arst_ovf_tick", 32'({ovf_w, ovf_s, tick_w, tick_s}), 32'h0);
        #4 rst_n = 1'b1;
        model_reset();
        hi = 0;
        repeat (4) begin
            cyc();
            if (tick_w || tick_s) hi++;
        end
        chk("arst_no_tick", 32'(hi), 32'd0);

        // Randomized traffic.
        pick[0] = 8'h00; pick[1] = 8'h01; pick[2] = 8'hFE; pick[3] = 8'hFF;
        for (int c = 0; c < 800; c++) begin
            if (c % 60 == 0) stepMode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) testStep = ~testStep;
            testReset     = ($urandom_range(0, 49) == 0);
            setValid      = ($urandom_range(0, 4) == 0);
            setChan       = 2'($urandom_range(0, 3));
            pick[4]       = 8'($urandom);
            setValue      = pick[$urandom_range(0, 4)];
            overflowClear = ($urandom_range(0, 9) == 0);
            chanEnable    = 4'($urandom);
            downMode      = 4'($urandom);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
